// File: rtl/wb_slave_decode_wdog.sv
// Wishbone address decoder for 4 slaves with a per-access watchdog that
// terminates a stalled access with an error-ack so a dead slave cannot hang the bus.
module wb_slave_decode_wdog #(
    parameter int unsigned DEC_LSB  = 26,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [31:0]  wbm_adr_i,
    input  logic [31:0]  wbm_dat_i,
    output logic [31:0]  wbm_dat_o,
    input  logic         wbm_cyc_i,
    input  logic         wbm_stb_i,
    input  logic         wbm_we_i,
    input  logic [3:0]   wbm_sel_i,
    input  logic [2:0]   wbm_cti_i,
    input  logic [1:0]   wbm_bte_i,
    output logic         wbm_ack_o,
    output logic [31:0]  wbs_adr_o,
    output logic [31:0]  wbs_dat_o,
    output logic         wbs_we_o,
    output logic [3:0]   wbs_sel_o,
    output logic [2:0]   wbs_cti_o,
    output logic [1:0]   wbs_bte_o,
    output logic [3:0]   wbs_cyc_o,
    output logic [3:0]   wbs_stb_o,
    input  logic [127:0] wbs_dat_i,
    input  logic [3:0]   wbs_ack_i,
    output logic         timeout_o,
    output logic [15:0]  timeout_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERRACK = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] wd_q, wd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack_fwd;
    logic [31:0] slave_dat;

    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_cti_o = wbm_cti_i;
    assign wbs_bte_o = wbm_bte_i;

    assign ack_fwd       = wbs_ack_i[idx_q] & wbm_stb_i;
    assign slave_dat     = wbs_dat_i[{idx_q, 5'b00000} +: 32];
    assign timeout_cnt_o = cnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            wd_q    <= 16'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        wbs_cyc_o = 4'b0000;
        wbs_stb_o = 4'b0000;
        wbm_ack_o = 1'b0;
        wbm_dat_o = 32'd0;
        timeout_o = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = 16'd0;
                if (wbm_cyc_i && wbm_stb_i) begin
                    idx_d   = wbm_adr_i[DEC_LSB +: 2];
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                wbs_cyc_o[idx_q] = wbm_cyc_i;
                wbs_stb_o[idx_q] = wbm_stb_i;
                wbm_ack_o        = ack_fwd;
                wbm_dat_o        = slave_dat;
                // Watchdog only counts genuinely stalled strobes.
                if (ack_fwd || !wbm_stb_i) begin
                    wd_d = 16'd0;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                    wd_d    = 16'd0;
                end else if (wbm_stb_i && !ack_fwd && (wd_q == TIMEOUT_V)) begin
                    state_d = ERRACK;
                    wd_d    = 16'd0;
                end
            end
            ERRACK: begin
                wbm_ack_o = wbm_stb_i;
                wbm_dat_o = ERR_DATA;
                timeout_o = 1'b1;
                wd_d      = 16'd0;
                if (cnt_q != 16'hffff) begin
                    cnt_d = cnt_q + 16'd1;
                end
                state_d = (wbm_cyc_i && wbm_stb_i) ? ACTIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
                wd_d    = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_slave_decode_wdog.sv
// Directed bench for wb_slave_decode_wdog: decode, ack steering, bursts,
// watchdog error-ack, ack-wins-at-timeout, and reset in the middle of a stall.
module tb_wb_slave_decode_wdog;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wbm_adr, wbm_dat_w, wbm_dat_r;
    logic         wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [3:0]   wbm_sel;
    logic [2:0]   wbm_cti;
    logic [1:0]   wbm_bte;
    logic [31:0]  wbs_adr, wbs_dat;
    logic         wbs_we;
    logic [3:0]   wbs_sel;
    logic [2:0]   wbs_cti;
    logic [1:0]   wbs_bte;
    logic [3:0]   wbs_cyc, wbs_stb;
    logic [127:0] wbs_dat_r;
    logic [3:0]   wbs_ack;
    logic         timeout;
    logic [15:0]  timeout_cnt;

    int errors = 0;
    int checks = 0;
    int bad_acks;

    always #5 clk = ~clk;

    wb_slave_decode_wdog dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbm_adr_i     (wbm_adr),
        .wbm_dat_i     (wbm_dat_w),
        .wbm_dat_o     (wbm_dat_r),
        .wbm_cyc_i     (wbm_cyc),
        .wbm_stb_i     (wbm_stb),
        .wbm_we_i      (wbm_we),
        .wbm_sel_i     (wbm_sel),
        .wbm_cti_i     (wbm_cti),
        .wbm_bte_i     (wbm_bte),
        .wbm_ack_o     (wbm_ack),
        .wbs_adr_o     (wbs_adr),
        .wbs_dat_o     (wbs_dat),
        .wbs_we_o      (wbs_we),
        .wbs_sel_o     (wbs_sel),
        .wbs_cti_o     (wbs_cti),
        .wbs_bte_o     (wbs_bte),
        .wbs_cyc_o     (wbs_cyc),
        .wbs_stb_o     (wbs_stb),
        .wbs_dat_i     (wbs_dat_r),
        .wbs_ack_i     (wbs_ack),
        .timeout_o     (timeout),
        .timeout_cnt_o (timeout_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic master_start(input logic [31:0] adr, input logic we);
        wbm_adr = adr;
        wbm_we  = we;
        wbm_cyc = 1'b1;
        wbm_stb = 1'b1;
    endtask

    task automatic master_drop();
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        wbm_cti = 3'b000;
        wbs_ack = 4'b0000;
    endtask

    initial begin
        rst       = 1'b1;
        wbm_adr   = 32'd0;
        wbm_dat_w = 32'd0;
        wbm_cyc   = 1'b0;
        wbm_stb   = 1'b0;
        wbm_we    = 1'b0;
        wbm_sel   = 4'hf;
        wbm_cti   = 3'b000;
        wbm_bte   = 2'b00;
        wbs_ack   = 4'b0000;
        wbs_dat_r = {32'h4444_4444, 32'h3333_3333, 32'h1234_5678, 32'haaaa_aaaa};

        step(); step();
        settle();
        check("rst_cyc", {28'd0, wbs_cyc}, 32'h0);
        check("rst_stb", {28'd0, wbs_stb}, 32'h0);
        check("rst_ack", {31'd0, wbm_ack}, 32'h0);
        check("rst_to",  {31'd0, timeout}, 32'h0);
        check("rst_cnt", {16'd0, timeout_cnt}, 32'h0);
        step();
        rst = 1'b0;

        // 1: write to slave 2, slave acks 3 cycles after its strobe
        step();
        master_start(32'h0800_0010, 1'b1);
        wbm_dat_w = 32'hcafe_f00d;
        settle();
        check("t1_idle_stb", {28'd0, wbs_stb}, 32'h0);
        check("t1_pass_adr", wbs_adr, 32'h0800_0010);
        check("t1_pass_dat", wbs_dat, 32'hcafe_f00d);
        check("t1_pass_we",  {31'd0, wbs_we}, 32'h1);
        step(); settle();
        check("t1_stb", {28'd0, wbs_stb}, 32'h4);
        check("t1_cyc", {28'd0, wbs_cyc}, 32'h4);
        check("t1_noack0", {31'd0, wbm_ack}, 32'h0);
        step(); settle();
        check("t1_noack1", {31'd0, wbm_ack}, 32'h0);
        step(); settle();
        check("t1_noack2", {31'd0, wbm_ack}, 32'h0);
        step();
        wbs_ack = 4'b0100;
        settle();
        check("t1_ack", {31'd0, wbm_ack}, 32'h1);
        step();
        master_drop();
        settle();
        check("t1_ack_end", {31'd0, wbm_ack}, 32'h0);
        check("t1_cyc_end", {28'd0, wbs_cyc}, 32'h0);

        // 2: read slave 1 while slave 0 pulses a stray ack
        step();
        master_start(32'h0400_0000, 1'b0);
        step();
        wbs_ack = 4'b0001;
        settle();
        check("t2_stray_ack", {31'd0, wbm_ack}, 32'h0);
        check("t2_stb", {28'd0, wbs_stb}, 32'h2);
        step();
        wbs_ack = 4'b0010;
        settle();
        check("t2_ack", {31'd0, wbm_ack}, 32'h1);
        check("t2_dat", wbm_dat_r, 32'h1234_5678);
        step();
        master_drop();

        // 3: incrementing burst of 4 to slave 3
        step();
        master_start(32'h0c00_0040, 1'b0);
        wbm_cti = 3'b010;
        wbm_bte = 2'b00;
        settle();
        check("t3_pass_cti", {29'd0, wbs_cti}, 32'h2);
        step();
        wbs_ack  = 4'b1000;
        bad_acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wbm_cti = 3'b111;
            settle();
            if (wbm_ack !== 1'b1) bad_acks++;
            if (wbs_cyc !== 4'b1000) bad_acks++;
            if (wbm_dat_r !== 32'h4444_4444) bad_acks++;
            step();
        end
        check("t3_burst", bad_acks, 0);
        master_drop();
        settle();
        check("t3_cyc_drop", {28'd0, wbs_cyc}, 32'h0);

        // 4: slave 0 never acks -> error-ack 256 cycles after slave strobe
        step();
        master_start(32'h0000_0100, 1'b0);
        settle();
        check("t4_idle_cyc", {28'd0, wbs_cyc}, 32'h0);
        step(); settle();
        check("t4_stb", {28'd0, wbs_stb}, 32'h1);
        bad_acks = 0;
        for (int i = 1; i <= 255; i++) begin
            step(); settle();
            if (wbm_ack !== 1'b0 || timeout !== 1'b0) bad_acks++;
        end
        check("t4_stall", bad_acks, 0);
        step(); settle();
        check("t4_err_ack", {31'd0, wbm_ack}, 32'h1);
        check("t4_err_dat", wbm_dat_r, 32'hdeadbeef);
        check("t4_to", {31'd0, timeout}, 32'h1);
        check("t4_err_stb", {28'd0, wbs_stb}, 32'h0);
        step();
        master_drop();
        settle();
        check("t4_to_pulse", {31'd0, timeout}, 32'h0);
        check("t4_cnt", {16'd0, timeout_cnt}, 32'h1);

        // 5: ack arriving on the timeout cycle wins
        step();
        master_start(32'h0000_0200, 1'b0);
        step();
        for (int i = 1; i <= 254; i++) step();
        step();
        wbs_ack = 4'b0001;
        settle();
        check("t5_ack", {31'd0, wbm_ack}, 32'h1);
        check("t5_dat", wbm_dat_r, 32'haaaa_aaaa);
        step();
        master_drop();
        settle();
        check("t5_to", {31'd0, timeout}, 32'h0);
        check("t5_cnt", {16'd0, timeout_cnt}, 32'h1);

        // 6: reset while the watchdog sits at 100
        step();
        master_start(32'h0400_0000, 1'b0);
        step();
        for (int i = 1; i <= 100; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        master_drop();
        settle();
        check("t6_cyc", {28'd0, wbs_cyc}, 32'h0);
        check("t6_stb", {28'd0, wbs_stb}, 32'h0);
        check("t6_ack", {31'd0, wbm_ack}, 32'h0);
        check("t6_dat", wbm_dat_r, 32'h0);
        check("t6_to", {31'd0, timeout}, 32'h0);
        check("t6_cnt", {16'd0, timeout_cnt}, 32'h0);
        step();
        master_start(32'h0800_0000, 1'b1);
        step();
        wbs_ack = 4'b0100;
        settle();
        check("t6_new_stb", {28'd0, wbs_stb}, 32'h4);
        check("t6_new_ack", {31'd0, wbm_ack}, 32'h1);
        step();
        master_drop();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
